branch_redirect_ctrl: RTL

//  Sequences taken-branch resolution in the EX stage of the LEGv8 pipeline. Decides B/CBZ outcome,

---
 rtl/branch_pkg.sv | 13 +
 rtl/branch_target_adder.sv | 15 +
 rtl/branch_redirect_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared state encoding and widths for the branch redirect controller
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam int ADDR_W_DEF  = 64;
    localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_target_adder.sv
// rtl/branch_target_adder.sv - combinational branch target: pc + (imm << 2), wrapping
module branch_target_adder
    import branch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    output logic [ADDR_W-1:0] target
);

    // Word offset to byte offset; carry out of the top bit is dropped on purpose.
    assign target = pc + (imm << 2);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-stage taken-branch redirect FSM; BRANCH_STATS_EN adds counters
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_imm,
    input  logic              ex_branch,
    input  logic              ex_uncond,
    input  logic              ex_zero,
    input  logic              fetch_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if,
    output logic              flush_id,
    output logic              stall_ex
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  resolved_cnt
`endif
);

    if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_param_check
        $error("branch_redirect_ctrl: FLUSH_CYCLES must be 0..15 and CNT_W >= 1");
    end

    state_t                 state;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [ADDR_W-1:0]      target;
    logic                   taken;

    // Both flags set resolves as unconditional, which the OR already gives.
    assign taken = ex_valid & (ex_uncond | (ex_branch & ex_zero));

    branch_target_adder #(
        .ADDR_W (ADDR_W)
    ) u_target_adder (
        .pc     (ex_pc),
        .imm    (ex_imm),
        .target (target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_if       <= 1'b0;
            flush_id       <= 1'b0;
            stall_ex       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (taken) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target;
                        flush_if       <= 1'b1;
                        flush_id       <= 1'b1;
                        stall_ex       <= 1'b1;
                    end
                end
                REDIRECT: begin
                    // EX inputs are ignored here; only the fetch handshake moves us on.
                    if (fetch_ready) begin
                        redirect_valid <= 1'b0;
                        redirect_pc    <= '0;
                        if (FLUSH_CYCLES > 0) begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES);
                        end else begin
                            state    <= IDLE;
                            flush_if <= 1'b0;
                            flush_id <= 1'b0;
                            stall_ex <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                        state    <= IDLE;
                        flush_if <= 1'b0;
                        flush_id <= 1'b0;
                        stall_ex <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= '0;
                    flush_if       <= 1'b0;
                    flush_id       <= 1'b0;
                    stall_ex       <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Statistics only see decisions made in IDLE; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt    <= '0;
            resolved_cnt <= '0;
        end else if (state == IDLE) begin
            if (ex_valid && (ex_branch || ex_uncond) && (resolved_cnt != '1))
                resolved_cnt <= resolved_cnt + CNT_W'(1);
            if (taken && (taken_cnt != '1))
                taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
